kaly_isr_seq: RTL and testbench
===============================

Name: kaly_isr_seq

Overview:
- Sequential AES state row-permutation engine; the decrypt-side counterpart of the forward ShiftRows stage in the encryption datapath.
- Accepts a 128-bit AES state over a valid/ready handshake.
- Applies inverse ShiftRows (row r rotated right by r) one row per clock.
- Returns the result over a valid/ready handshake.
- A parameter selects the forward direction, so the same engine can cross-check the encrypt path.

Parameters:
- INVERSE, 1, 1 = inverse ShiftRows (rotate row r right by r); 0 = forward ShiftRows (rotate left by r).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; returns FSM to IDLE and drops any in-flight state.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  engine can accept in_data this cycle.
- in_data  input  128  AES state, column-major: byte i = 4*c + r at bits [127-8i -: 8].
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  permuted state, same byte layout.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (rst_n low, async):
  - FSM = IDLE, row counter = 0, state register = 0.
  - out_valid = 0, busy = 0, in_ready = 0 while rst_n is low; in_ready = 1 from the first cycle after release.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_data, set row = 1, go to SHIFT.
  - SHIFT: busy = 1, in_ready = 0. Each cycle, rotate the 4 bytes of row `row` by one position only when INVERSE=1 is not sufficient:
    - Row r is rotated by r positions in a single step: out[r][c] = in[r][(c-r) mod 4] for inverse, in[r][(c+r) mod 4] for forward.
    - Rows 0 and other rows are untouched that cycle.
    - row increments 1→2→3; after row 3 is applied, go to DONE.
  - DONE: out_valid = 1, out_data = state register, held stable until out_ready.
    - On out_ready: if in_valid, capture new in_data and go straight to SHIFT (back-to-back); otherwise go to IDLE.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready); combinational from out_ready only.
- Latency:
  - Acceptance edge T.
  - Rows 1, 2, 3 applied on edges T+1, T+2, T+3.
  - out_valid high in the cycle after T+3.
  - Throughput: one state per 4 cycles with back-to-back handshakes.
- Row 0 is never modified. A 2-bit row counter never wraps past 3.
- clr has priority over every handshake:
  - Any state → IDLE next cycle; out_valid deasserts.
  - A simultaneous in_valid is not accepted: in_ready is forced to 0 while clr = 1.
- Async reset mid-SHIFT or mid-DONE discards data immediately; no partial result ever appears on out_data with out_valid = 1.
- out_data in non-DONE states: undefined for the consumer. The implementation drives the state register; the bench must not check it.
- in_data is ignored whenever in_ready = 0.

Decomposition:
- Shared package kaly_aes_pkg:
  - typedef aes_state_t (128-bit).
  - Byte-index function idx(r, c) = 4*c + r.
  - FSM state enum {IDLE, SHIFT, DONE}.
  - Localparam NB = 4.
- Sub-module kaly_row_rot (combinational):
  - Inputs: 128-bit state, 2-bit row, 1-bit direction.
  - Output: state with only that row rotated by `row` positions.
  - The FSM wrapper instantiates it once.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then release → out_valid = 0, busy = 0, in_ready = 1.
- Inverse, bytes 00..0f in order, out_ready held 1 → exactly 4 cycles after acceptance, out_data = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
- Round trip: INVERSE=0 instance gets 00..0f → out_data = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. Feed that to the INVERSE=1 instance → 00..0f.
- Backpressure and back-to-back:
  - out_ready = 0 for 5 cycles after out_valid → out_data and out_valid stay stable.
  - Raise out_ready together with in_valid → new state accepted that cycle, next out_valid 4 cycles later.
- Abort cases:
  - clr asserted at SHIFT row 2 → IDLE next cycle, no out_valid.
  - rst_n pulsed low during DONE → out_valid drops asynchronously.
  - Subsequent vector processes correctly.
- Random: 1000 random states with random out_ready stalls → every output equals the reference model, in order, with no drops or duplicates.

Source files
------------

// File: rtl/kaly_aes_pkg.sv
// Shared AES state types and helpers for the row-permutation engine.
// State is column-major: byte i = 4*c + r, byte 0 in the most significant bits.
package kaly_aes_pkg;

   localparam int unsigned NB = 4;

   // Element 0 is the MS byte, so byte i sits at bits [127-8i -: 8].
   typedef logic [0:15][7:0] aes_state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   // 4*c + r packs exactly into {c, r}.
   function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
      return {c, r};
   endfunction

endpackage

// File: rtl/kaly_row_rot.sv
// Rotates a single row of the AES state by `row` byte positions.
// dir = 1 rotates right (inverse ShiftRows), dir = 0 rotates left (forward ShiftRows).
module kaly_row_rot
   import kaly_aes_pkg::*;
(
   input  logic [127:0] st_in,
   input  logic [1:0]   row,
   input  logic         dir,
   output logic [127:0] st_out
);

   aes_state_t s;
   aes_state_t o;
   logic [1:0] cc;
   logic [1:0] src;

   assign s = st_in;

   always_comb begin
      o   = s;
      cc  = '0;
      src = '0;
      for (int unsigned c = 0; c < NB; c++) begin
         cc  = 2'(c);
         src = dir ? (cc - row) : (cc + row);
         o[idx(row, cc)] = s[idx(row, src)];
      end
   end

   assign st_out = o;

endmodule

// File: rtl/kaly_isr_seq.sv
// Sequential ShiftRows engine: accepts a state, permutes rows 1..3 one per clock,
// then presents the result until the consumer takes it.
module kaly_isr_seq
   import kaly_aes_pkg::*;
#(
   parameter bit INVERSE = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   fsm_t         state, state_nxt;
   logic [1:0]   row, row_nxt;
   logic [127:0] st, st_nxt;
   logic [127:0] rot;

   kaly_row_rot u_rot (
      .st_in  (st),
      .row    (row),
      .dir    (INVERSE),
      .st_out (rot)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         row   <= '0;
         st    <= '0;
      end else begin
         state <= state_nxt;
         row   <= row_nxt;
         st    <= st_nxt;
      end
   end

   // Next-state: capture, per-row rotation, hand-off; clr overrides everything
   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      st_nxt    = st;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               st_nxt    = in_data;
               row_nxt   = 2'd1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            st_nxt = rot;
            if (row == 2'd3) begin
               state_nxt = DONE;
            end else begin
               row_nxt = row + 2'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid && in_ready) begin
                  st_nxt    = in_data;
                  row_nxt   = 2'd1;
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (clr) begin
         state_nxt = IDLE;
         row_nxt   = '0;
         st_nxt    = '0;
      end
   end

   // Outputs decoded from state; in_ready also sees out_ready for back-to-back
   always_comb begin
      out_valid = (state == DONE);
      busy      = (state == SHIFT);
      in_ready  = rst_n && !clr &&
                  ((state == IDLE) || ((state == DONE) && out_ready));
   end

   assign out_data = st;

endmodule

// File: tb/tb_kaly_isr_seq.sv
// Self-checking bench for kaly_isr_seq: directed scenarios plus a randomised
// scoreboard run against an independent ShiftRows reference model.
module tb_kaly_isr_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_data, out_data;
   logic         f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_busy;
   logic [127:0] f_in_data, f_out_data;

   int           checks   = 0;
   int           failures = 0;
   logic [127:0] q[$];

   localparam logic [127:0] SEQ     = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] INV_EXP = 128'h000d0a07_04010e0b_0805020f_0c090603;
   localparam logic [127:0] FWD_EXP = 128'h00050a0f_04090e03_080d0207_0c01060b;

   always #5 clk = ~clk;

   kaly_isr_seq #(.INVERSE(1'b1)) u_inv (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   kaly_isr_seq #(.INVERSE(1'b0)) u_fwd (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
      .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
      .busy(f_busy)
   );

   function automatic logic [127:0] ref_sr(input logic [127:0] s, input bit inv);
      logic [127:0] o;
      int src;
      o = s;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      f_in_valid = 1'b0; f_in_data = '0; f_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b busy=%b, required 0 0 0",
                     in_ready, out_valid, busy);
         end
         cyc();
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                  in_ready, out_valid, busy);
      end
      cyc();
   endtask

   task automatic test_inverse_basic();
      logic [127:0] exp;
      in_valid = 1'b1; in_data = SEQ; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_accept: in_ready=%b, required 1", in_ready);
      end
      q.push_back(INV_EXP);
      cyc();
      in_valid = 1'b0; in_data = rnd128();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_shift: busy=%b out_valid=%b, required 1 0", busy, out_valid);
      end
      cyc(); cyc();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_early: out_valid=%b after 3 edges, required 0", out_valid);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL basic_latency: out_valid=%b after 4 edges, required 1", out_valid);
      end
      exp = q.pop_front();
      checks++;
      if (out_data !== exp) begin
         failures++;
         $display("FAIL basic_data: got %h, required %h", out_data, exp);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      cyc();
   endtask

   task automatic test_round_trip();
      logic [127:0] mid, exp;
      bit ok;
      f_in_valid = 1'b1; f_in_data = SEQ; f_out_ready = 1'b1;
      cyc();
      f_in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (f_out_valid) begin ok = 1'b1; break; end
         cyc();
      end
      checks++;
      if (!ok || f_out_data !== FWD_EXP) begin
         failures++;
         $display("FAIL fwd_data: valid=%b got %h, required %h", f_out_valid, f_out_data, FWD_EXP);
      end
      mid = f_out_data;
      cyc();
      in_valid = 1'b1; in_data = mid; out_ready = 1'b1;
      q.push_back(SEQ);
      cyc();
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
         cyc();
      end
      exp = q.pop_front();
      checks++;
      if (!ok || out_data !== exp) begin
         failures++;
         $display("FAIL round_trip: valid=%b got %h, required %h", out_valid, out_data, exp);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [127:0] v1, v2, exp;
      bit ok, stable;
      v1 = rnd128(); v2 = rnd128();
      in_valid = 1'b1; in_data = v1; out_ready = 1'b0;
      q.push_back(ref_sr(v1, 1'b1));
      cyc();
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
         cyc();
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_timeout: out_valid=%b, required 1", out_valid);
      end
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== q[0]) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL bp_stable: out_valid=%b data %h, required 1 %h", out_valid, out_data, q[0]);
      end
      cyc();
      out_ready = 1'b1; in_valid = 1'b1; in_data = v2;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
      end
      exp = q.pop_front();
      checks++;
      if (out_data !== exp) begin
         failures++;
         $display("FAIL b2b_first: got %h, required %h", out_data, exp);
      end
      q.push_back(ref_sr(v2, 1'b1));
      cyc();
      in_valid = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_early: out_valid=%b busy=%b, required 0 1", out_valid, busy);
      end
      cyc();
      @(negedge clk);
      exp = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
         failures++;
         $display("FAIL b2b_second: valid=%b got %h, required 1 %h", out_valid, out_data, exp);
      end
      cyc();
   endtask

   task automatic test_clr_abort();
      bit seen;
      in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      clr = 1'b1; in_valid = 1'b1; in_data = rnd128();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL clr_ready: in_ready=%b busy=%b, required 0 1", in_ready, busy);
      end
      cyc();
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL clr_idle: busy=%b out_valid=%b in_ready=%b, required 0 0 1",
                  busy, out_valid, in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL clr_quiet: activity seen=%b after abort, required 0", seen);
      end
      cyc();
   endtask

   task automatic test_reset_in_done();
      logic [127:0] v, exp;
      bit ok;
      in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
         cyc();
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rst_done_reach: out_valid=%b, required 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_async: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
      end
      cyc();
      rst_n = 1'b1;
      v = rnd128();
      in_valid = 1'b1; in_data = v; out_ready = 1'b1;
      q.push_back(ref_sr(v, 1'b1));
      cyc();
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
         cyc();
      end
      exp = q.pop_front();
      checks++;
      if (!ok || out_data !== exp) begin
         failures++;
         $display("FAIL rst_recover: valid=%b got %h, required %h", out_valid, out_data, exp);
      end
      cyc();
   endtask

   task automatic test_random();
      int sent = 0;
      int recv = 0;
      int cycles = 0;
      logic [127:0] exp;
      in_valid = 1'b0; out_ready = 1'b0;
      while ((sent < 1000 || recv < 1000) && cycles < 20000) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data   = rnd128();
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL rnd_extra: output %h with empty scoreboard", out_data);
            end else begin
               exp = q.pop_front();
               if (out_data !== exp) begin
                  failures++;
                  $display("FAIL rnd_data[%0d]: got %h, required %h", recv, out_data, exp);
               end
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_sr(in_data, 1'b1));
            sent++;
         end
         cyc();
         cycles++;
      end
      in_valid = 1'b0;
      checks++;
      if (recv != 1000 || q.size() != 0) begin
         failures++;
         $display("FAIL rnd_count: received %0d leftover %0d, required 1000 0", recv, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_inverse_basic();
      test_round_trip();
      test_back_to_back();
      test_clr_abort();
      q.delete();
      test_reset_in_done();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
